// File: rtl/axi_bus_arbiter.sv
// Two-port blocking requester arbiter onto a single AXI3 master port.
// One granted request at a time becomes an AR/R read or an AW/W/B write burst.
module axi_bus_arbiter #(
  parameter logic [3:0] AXI_ID = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_is_write,
  input  logic [63:0] req_addr,
  input  logic [5:0]  req_size,
  input  logic [7:0]  req_len,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic [1:0]  resp_ready,
  output logic [1:0]  resp_last,
  output logic [31:0] resp_data,
  output logic        bus_error,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0]  r_state;
  logic        r_grant;
  logic        r_last_grant;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [3:0]  r_len;

  logic        w_pick;
  logic        w_wlast;

  // Round-robin only matters when both ports are pending.
  assign w_pick  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_wlast = (r_cnt == r_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
          r_state      <= req_is_write[w_pick] ? S_AW : S_AR;
        end
        S_AR: if (arready) r_state <= S_R;
        S_R:  if (rvalid && rlast) r_state <= S_IDLE;
        S_AW: if (awready) begin
          r_state <= S_W;
          r_cnt   <= 4'd0;
        end
        S_W: if (wready) begin
          if (w_wlast) r_state <= S_B;
          else         r_cnt   <= r_cnt + 4'd1;
        end
        S_B:  if (bvalid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: request latches are pure datapath, only read after a grant loads them, so no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && |req_valid) begin
      r_addr <= w_pick ? req_addr[63:32]  : req_addr[31:0];
      r_size <= w_pick ? req_size[5:3]    : req_size[2:0];
      r_len  <= w_pick ? req_len[7:4]     : req_len[3:0];
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = r_size;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);

  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awlen   = r_len;
  assign awsize  = r_size;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (r_state == S_AW);

  assign wid     = AXI_ID;
  assign wdata   = r_grant ? req_data[63:32] : req_data[31:0];
  assign wstrb   = r_grant ? req_strobe[7:4] : req_strobe[3:0];
  assign wlast   = w_wlast;
  assign wvalid  = (r_state == S_W);
  assign bready  = (r_state == S_B);

  // NOTE: every output written here gets a default first, so no latches are inferred.
  always_comb begin
    resp_ready = 2'b00;
    resp_last  = 2'b00;
    resp_data  = 32'd0;
    bus_error  = 1'b0;
    case (r_state)
      S_R: begin
        resp_data = rdata;
        if (rvalid) begin
          resp_ready[r_grant] = 1'b1;
          resp_last[r_grant]  = rlast;
          bus_error           = (rresp != 2'b00);
        end
      end
      S_W: if (wready && !w_wlast) resp_ready[r_grant] = 1'b1;
      S_B: if (bvalid) begin
        resp_ready[r_grant] = 1'b1;
        resp_last[r_grant]  = 1'b1;
        bus_error           = (bresp != 2'b00);
      end
      default: ;
    endcase
  end

endmodule
